drum_mul_pipe: RTL

//   Parametrised, pipelined DRUM approximate unsigned multiplier with valid/ready streaming handshake.

---
 rtl/drum_pkg.sv | 24 ++
 rtl/drum_operand_prep.sv | 43 ++++
 rtl/drum_mul_pipe.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/drum_pkg.sv
// Shared definitions for the DRUM approximate multiplier.
//   lead_one_idx : index of the most significant set bit (0 for an all-zero word)
//   drum_sh_w    : width of a shift-sum field for a given operand width
// Operand words up to LOD_W bits are supported by the leading-one search.
package drum_pkg;

  localparam int LOD_W = 32;
  localparam int IDX_W = 5;

  function automatic logic [IDX_W-1:0] lead_one_idx(input logic [LOD_W-1:0] x);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < LOD_W; i++) begin
      if (x[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  // Wide enough for the sum of two per-operand shifts, max 2*(n-K_W).
  function automatic int drum_sh_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/drum_operand_prep.sv
// Per-operand DRUM preparation: leading-one detection, mantissa selection
// and shift amount. Purely combinational.
//   x     : unsigned operand (N_W bits)
//   mant  : K_W-bit mantissa; forced LSB of 1 when the operand is truncated
//   shift : left shift that restores the mantissa's weight
module drum_operand_prep
  import drum_pkg::*;
#(
  parameter int N_W  = 16,
  parameter int K_W  = 6,
  parameter int SH_W = 5
) (
  input  logic [N_W-1:0]  x,
  output logic [K_W-1:0]  mant,
  output logic [SH_W-1:0] shift
);

  localparam logic [IDX_W-1:0] KM1 = IDX_W'(K_W - 1);

  logic [LOD_W-1:0] x_ext;
  logic [IDX_W-1:0] k;
  logic [IDX_W-1:0] sh_raw;
  logic [K_W-1:0]   trunc;

  always_comb begin
    x_ext          = '0;
    x_ext[N_W-1:0] = x;
    k              = lead_one_idx(x_ext);
    sh_raw         = '0;
    trunc          = '0;
    mant           = x[K_W-1:0];
    shift          = '0;
    if (k > KM1) begin
      // Shifting the leading one down to bit K_W-1 keeps the K_W-2 bits
      // below it; the dropped tail is replaced by a 1 for unbiased rounding.
      sh_raw = k - KM1;
      trunc  = K_W'(x >> sh_raw);
      mant   = trunc | K_W'(1);
      shift  = SH_W'(sh_raw);
    end
  end

endmodule

// File: rtl/drum_mul_pipe.sv
// Pipelined DRUM approximate unsigned multiplier with valid/ready streaming.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : operand handshake (in_a, in_b, in_tag)
//   out_valid/out_ready  : result handshake (out_p, out_tag)
// Stages: S1 mantissas + shift sum + tag, S2 mantissa product, S3 shifted
// product. Each stage advances when empty or when the next stage advances.
// Build option DRUM_EXACT_MODE_EN adds in_exact: operations flagged with it
// return the exact in_a*in_b through the same pipeline.
module drum_mul_pipe
  import drum_pkg::*;
#(
  parameter int N_W   = 16,
  parameter int K_W   = 6,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N_W-1:0]     in_a,
  input  logic [N_W-1:0]     in_b,
  input  logic [TAG_W-1:0]   in_tag,
`ifdef DRUM_EXACT_MODE_EN
  input  logic               in_exact,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*N_W-1:0]   out_p,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int SH_W = drum_sh_w(N_W);
  localparam int P_W  = 2 * N_W;
`ifdef DRUM_EXACT_MODE_EN
  // Mantissa lanes widen to the full operand so exact ops share the multiplier.
  localparam int MW = N_W;
`else
  localparam int MW = K_W;
`endif

  typedef struct packed {
    logic [MW-1:0]    mant_a;
    logic [MW-1:0]    mant_b;
    logic [SH_W-1:0]  sh_sum;
    logic [TAG_W-1:0] tag;
  } s1_t;

  logic [K_W-1:0]  mant_a_w, mant_b_w;
  logic [SH_W-1:0] sh_a_w, sh_b_w;

  drum_operand_prep #(.N_W(N_W), .K_W(K_W), .SH_W(SH_W)) u_prep_a (
    .x     (in_a),
    .mant  (mant_a_w),
    .shift (sh_a_w)
  );

  drum_operand_prep #(.N_W(N_W), .K_W(K_W), .SH_W(SH_W)) u_prep_b (
    .x     (in_b),
    .mant  (mant_b_w),
    .shift (sh_b_w)
  );

  logic vld_p1_q, vld_p1_d;
  logic vld_p2_q, vld_p2_d;
  logic vld_p3_q, vld_p3_d;
  logic rdy_p2, rdy_p3;

  s1_t              s_p1_q, s_p1_d, s_new;
  logic [2*MW-1:0]  prod_p2_q, prod_p2_d;
  logic [SH_W-1:0]  sh_p2_q, sh_p2_d;
  logic [TAG_W-1:0] tag_p2_q, tag_p2_d;
  logic [P_W-1:0]   p_p3_q, p_p3_d;
  logic [TAG_W-1:0] tag_p3_q, tag_p3_d;

  // Ready chain: a stage may load when it is empty or its content moves on.
  always_comb begin
    rdy_p3   = !vld_p3_q || out_ready;
    rdy_p2   = !vld_p2_q || rdy_p3;
    in_ready = !vld_p1_q || rdy_p2;
    vld_p1_d = in_ready ? in_valid : vld_p1_q;
    vld_p2_d = rdy_p2   ? vld_p1_q : vld_p2_q;
    vld_p3_d = rdy_p3   ? vld_p2_q : vld_p3_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      vld_p3_q <= 1'b0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      vld_p3_q <= vld_p3_d;
    end
  end

  // ---- S1: mantissas, shift sum, tag ----
  always_comb begin
    s_new.mant_a = MW'(mant_a_w);
    s_new.mant_b = MW'(mant_b_w);
    s_new.sh_sum = sh_a_w + sh_b_w;
    s_new.tag    = in_tag;
`ifdef DRUM_EXACT_MODE_EN
    if (in_exact) begin
      s_new.mant_a = in_a;
      s_new.mant_b = in_b;
      s_new.sh_sum = '0;
    end
`endif
    s_p1_d = (in_ready && in_valid) ? s_new : s_p1_q;
  end

  always_ff @(posedge clk) begin
    s_p1_q <= s_p1_d;
  end

  // ---- S2: mantissa product ----
  always_comb begin
    prod_p2_d = prod_p2_q;
    sh_p2_d   = sh_p2_q;
    tag_p2_d  = tag_p2_q;
    if (rdy_p2 && vld_p1_q) begin
      prod_p2_d = (2*MW)'(s_p1_q.mant_a) * (2*MW)'(s_p1_q.mant_b);
      sh_p2_d   = s_p1_q.sh_sum;
      tag_p2_d  = s_p1_q.tag;
    end
  end

  always_ff @(posedge clk) begin
    prod_p2_q <= prod_p2_d;
    sh_p2_q   <= sh_p2_d;
    tag_p2_q  <= tag_p2_d;
  end

  // ---- S3: barrel shift to the output register ----
  always_comb begin
    p_p3_d   = p_p3_q;
    tag_p3_d = tag_p3_q;
    if (rdy_p3 && vld_p2_q) begin
      p_p3_d   = P_W'(prod_p2_q) << sh_p2_q;
      tag_p3_d = tag_p2_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_p3_q   <= '0;
      tag_p3_q <= '0;
    end else begin
      p_p3_q   <= p_p3_d;
      tag_p3_q <= tag_p3_d;
    end
  end

  assign out_valid = vld_p3_q;
  assign out_p     = p_p3_q;
  assign out_tag   = tag_p3_q;

endmodule
